// File: rtl/writeback_rf_sb_if.sv
// Writeback/register-file bus: handshake, source operands, scoreboard issue and read ports.
// Optional macro WB_BYPASS_EN is consumed by writeback_rf_sb, not by this interface.
interface writeback_rf_sb_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              wb_valid;
  logic              wb_ready;
  logic [1:0]        W_Control;
  logic [DATA_W-1:0] aluout;
  logic [DATA_W-1:0] memout;
  logic [DATA_W-1:0] pcout;
  logic [DATA_W-1:0] npc;
  logic [ADDR_W-1:0] dr;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_dr;
  logic [ADDR_W-1:0] sr1;
  logic [ADDR_W-1:0] sr2;
  logic [DATA_W-1:0] VSR1;
  logic [DATA_W-1:0] VSR2;
  logic              sr1_busy;
  logic              sr2_busy;
  logic [2:0]        psr;
  logic              init_done;

  modport master (
    output wb_valid, W_Control, aluout, memout, pcout, npc, dr,
           iss_valid, iss_dr, sr1, sr2,
    input  wb_ready, VSR1, VSR2, sr1_busy, sr2_busy, psr, init_done
  );

  modport slave (
    input  wb_valid, W_Control, aluout, memout, pcout, npc, dr,
           iss_valid, iss_dr, sr1, sr2,
    output wb_ready, VSR1, VSR2, sr1_busy, sr2_busy, psr, init_done
  );
endinterface

// File: rtl/writeback_rf_sb.sv
// Writeback stage, register file, NZP codes and pending-write scoreboard with a post-reset clear.
// Optional macro WB_BYPASS_EN: forwards the accepted writeback data to same-cycle reads.
module writeback_rf_sb #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input logic             clock,
  input logic             reset,
  writeback_rf_sb_if.slave bus
);
  localparam int NREGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] cnt_r;
  logic [DATA_W-1:0] regs_r [NREGS];
  logic [NREGS-1:0]  busy_r;
  logic [2:0]        psr_r;
  logic              wb_ready_r;
  logic              init_done_r;

  logic [DATA_W-1:0] din_s;
  logic              accept_s;
  logic [NREGS-1:0]  set_s;
  logic [NREGS-1:0]  clr_s;
  logic [NREGS-1:0]  busy_nxt_s;
  logic [DATA_W-1:0] vsr1_s;
  logic [DATA_W-1:0] vsr2_s;
  logic              busy1_s;
  logic              busy2_s;

  function automatic logic [2:0] nzp_of(input logic [DATA_W-1:0] v);
    if (v[DATA_W-1]) begin
      return 3'b100;
    end else if (v != {DATA_W{1'b0}}) begin
      return 3'b001;
    end else begin
      return 3'b010;
    end
  endfunction

  function automatic logic [NREGS-1:0] onehot(input logic [ADDR_W-1:0] idx);
    return {{(NREGS-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Writeback source select.
  always_comb begin
    din_s = bus.aluout;
    case (bus.W_Control)
      2'd0:    din_s = bus.aluout;
      2'd1:    din_s = bus.memout;
      2'd2:    din_s = bus.pcout;
      2'd3:    din_s = bus.npc;
      default: din_s = bus.aluout;
    endcase
  end

  assign accept_s = bus.wb_valid && wb_ready_r;

  // Scoreboard next state: a same-index issue overrides the retiring clear.
  always_comb begin
    set_s      = (state_r == ST_RUN && bus.iss_valid) ? onehot(bus.iss_dr) : {NREGS{1'b0}};
    clr_s      = accept_s ? onehot(bus.dr) : {NREGS{1'b0}};
    busy_nxt_s = (busy_r & ~clr_s) | set_s;
  end

  // Read ports, optionally forwarding the writeback being accepted this cycle.
  always_comb begin
    vsr1_s  = regs_r[bus.sr1];
    vsr2_s  = regs_r[bus.sr2];
    busy1_s = busy_r[bus.sr1];
    busy2_s = busy_r[bus.sr2];
`ifdef WB_BYPASS_EN
    if (accept_s && bus.sr1 == bus.dr) begin
      vsr1_s  = din_s;
      busy1_s = set_s[bus.sr1];
    end else begin
      vsr1_s  = regs_r[bus.sr1];
      busy1_s = busy_r[bus.sr1];
    end
    if (accept_s && bus.sr2 == bus.dr) begin
      vsr2_s  = din_s;
      busy2_s = set_s[bus.sr2];
    end else begin
      vsr2_s  = regs_r[bus.sr2];
      busy2_s = busy_r[bus.sr2];
    end
`endif
  end

  // Clear/run sequencer, register file writes, condition codes and scoreboard.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_CLEAR;
      cnt_r       <= {ADDR_W{1'b0}};
      busy_r      <= {NREGS{1'b0}};
      psr_r       <= 3'b000;
      wb_ready_r  <= 1'b0;
      init_done_r <= 1'b0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          regs_r[cnt_r] <= {DATA_W{1'b0}};
          if (cnt_r == LAST_IDX) begin
            state_r     <= ST_RUN;
            wb_ready_r  <= 1'b1;
            init_done_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + ADDR_W'(1);
          end
        end
        ST_RUN: begin
          if (accept_s) begin
            regs_r[bus.dr] <= din_s;
            psr_r          <= nzp_of(din_s);
          end else begin
            psr_r <= psr_r;
          end
          busy_r <= busy_nxt_s;
        end
        default: begin
          state_r    <= ST_CLEAR;
          wb_ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wb_ready  = wb_ready_r;
  assign bus.init_done = init_done_r;
  assign bus.psr       = psr_r;
  assign bus.VSR1      = vsr1_s;
  assign bus.VSR2      = vsr2_s;
  assign bus.sr1_busy  = busy1_s;
  assign bus.sr2_busy  = busy2_s;
endmodule

// File: tb/tb_writeback_rf_sb.sv
// Directed self-checking bench for writeback_rf_sb (DATA_W=16, ADDR_W=3).
// Honours WB_BYPASS_EN to select the expected same-cycle read behaviour.
module tb_writeback_rf_sb;
  logic clock;
  logic reset;
  int   checks;
  int   failures;

  writeback_rf_sb_if #(.DATA_W(16), .ADDR_W(3)) bus_if ();

  writeback_rf_sb #(.DATA_W(16), .ADDR_W(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wb(input logic [1:0] sel, input logic [15:0] val, input logic [2:0] d);
    bus_if.W_Control = sel;
    bus_if.aluout    = (sel == 2'd0) ? val : 16'h1111;
    bus_if.memout    = (sel == 2'd1) ? val : 16'h2222;
    bus_if.pcout     = (sel == 2'd2) ? val : 16'h3333;
    bus_if.npc       = (sel == 2'd3) ? val : 16'h4444;
    bus_if.dr        = d;
    bus_if.wb_valid  = 1'b1;
    tick();
    bus_if.wb_valid  = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus_if.wb_valid  = 1'b0;
    bus_if.W_Control = 2'd0;
    bus_if.aluout    = 16'h0000;
    bus_if.memout    = 16'h0000;
    bus_if.pcout     = 16'h0000;
    bus_if.npc       = 16'h0000;
    bus_if.dr        = 3'd0;
    bus_if.iss_valid = 1'b0;
    bus_if.iss_dr    = 3'd0;
    bus_if.sr1       = 3'd0;
    bus_if.sr2       = 3'd0;
    tick();
    tick();
    check_eq("rst_ready", {31'd0, bus_if.wb_ready}, 32'd0);
    check_eq("rst_init", {31'd0, bus_if.init_done}, 32'd0);
    check_eq("rst_psr", {29'd0, bus_if.psr}, 32'd0);

    // Clear sequence with a writeback and an issue held pending throughout.
    reset = 1'b0;
    bus_if.wb_valid  = 1'b1;
    bus_if.W_Control = 2'd0;
    bus_if.aluout    = 16'h1234;
    bus_if.dr        = 3'd1;
    bus_if.iss_valid = 1'b1;
    bus_if.iss_dr    = 3'd5;
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("clr_ready%0d", i), {31'd0, bus_if.wb_ready}, 32'd0);
      check_eq($sformatf("clr_psr%0d", i), {29'd0, bus_if.psr}, 32'd0);
      tick();
    end
    bus_if.iss_valid = 1'b0;
    check_eq("run_ready", {31'd0, bus_if.wb_ready}, 32'd1);
    check_eq("run_init", {31'd0, bus_if.init_done}, 32'd1);
    check_eq("run_psr", {29'd0, bus_if.psr}, 32'd0);
    bus_if.sr2 = 3'd5;
    #1;
    check_eq("clr_iss_ignored", {31'd0, bus_if.sr2_busy}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      bus_if.sr1 = 3'(i);
      #1;
`ifdef WB_BYPASS_EN
      check_eq($sformatf("clr_reg%0d", i), {16'd0, bus_if.VSR1}, (i == 1) ? 32'h1234 : 32'h0);
`else
      check_eq($sformatf("clr_reg%0d", i), {16'd0, bus_if.VSR1}, 32'h0);
`endif
    end
    tick();
    bus_if.wb_valid = 1'b0;
    bus_if.sr1 = 3'd1;
    #1;
    check_eq("first_run_write", {16'd0, bus_if.VSR1}, 32'h1234);
    check_eq("first_run_psr", {29'd0, bus_if.psr}, 32'b001);

    // Writeback sources and condition codes.
    wb(2'd1, 16'h8001, 3'd3);
    bus_if.sr1 = 3'd3;
    #1;
    check_eq("mem_data", {16'd0, bus_if.VSR1}, 32'h8001);
    check_eq("mem_psr", {29'd0, bus_if.psr}, 32'b100);
    wb(2'd0, 16'h0000, 3'd4);
    check_eq("alu_zero_psr", {29'd0, bus_if.psr}, 32'b010);
    wb(2'd3, 16'h3001, 3'd5);
    bus_if.sr2 = 3'd5;
    #1;
    check_eq("npc_data", {16'd0, bus_if.VSR2}, 32'h3001);
    check_eq("npc_psr", {29'd0, bus_if.psr}, 32'b001);
    tick();
    check_eq("psr_hold", {29'd0, bus_if.psr}, 32'b001);

    // Scoreboard set, clear, set-wins, independent indices.
    bus_if.iss_valid = 1'b1;
    bus_if.iss_dr    = 3'd2;
    tick();
    bus_if.iss_valid = 1'b0;
    bus_if.sr1 = 3'd2;
    bus_if.sr2 = 3'd2;
    #1;
    check_eq("sb_set1", {31'd0, bus_if.sr1_busy}, 32'd1);
    check_eq("sb_set2", {31'd0, bus_if.sr2_busy}, 32'd1);
    wb(2'd0, 16'h0042, 3'd2);
    check_eq("sb_clr", {31'd0, bus_if.sr1_busy}, 32'd0);
    check_eq("sb_clr_data", {16'd0, bus_if.VSR1}, 32'h0042);
    bus_if.iss_valid = 1'b1;
    bus_if.iss_dr    = 3'd2;
    wb(2'd0, 16'h0077, 3'd2);
    bus_if.iss_valid = 1'b0;
    check_eq("sb_setwins", {31'd0, bus_if.sr1_busy}, 32'd1);
    check_eq("sb_setwins_data", {16'd0, bus_if.VSR2}, 32'h0077);
    bus_if.iss_valid = 1'b1;
    bus_if.iss_dr    = 3'd3;
    wb(2'd0, 16'h0010, 3'd2);
    bus_if.iss_valid = 1'b0;
    bus_if.sr2 = 3'd3;
    #1;
    check_eq("sb_indep_clr", {31'd0, bus_if.sr1_busy}, 32'd0);
    check_eq("sb_indep_set", {31'd0, bus_if.sr2_busy}, 32'd1);

    // Same-cycle read of the register being written.
    bus_if.W_Control = 2'd2;
    bus_if.pcout     = 16'h4000;
    bus_if.dr        = 3'd7;
    bus_if.sr2       = 3'd7;
    bus_if.wb_valid  = 1'b1;
    #1;
`ifdef WB_BYPASS_EN
    check_eq("bypass_same_cycle", {16'd0, bus_if.VSR2}, 32'h4000);
`else
    check_eq("nobypass_same_cycle", {16'd0, bus_if.VSR2}, 32'h0000);
`endif
    tick();
    bus_if.wb_valid = 1'b0;
    check_eq("pc_after_edge", {16'd0, bus_if.VSR2}, 32'h4000);

    // Reset mid-operation, including alongside an accepted writeback and mid-clear.
    wb(2'd0, 16'h00FF, 3'd6);
    bus_if.iss_valid = 1'b1;
    bus_if.iss_dr    = 3'd1;
    tick();
    bus_if.iss_valid = 1'b0;
    bus_if.sr1 = 3'd6;
    bus_if.sr2 = 3'd1;
    #1;
    check_eq("pre_rst_r6", {16'd0, bus_if.VSR1}, 32'h00FF);
    check_eq("pre_rst_busy1", {31'd0, bus_if.sr2_busy}, 32'd1);
    reset = 1'b1;
    bus_if.W_Control = 2'd0;
    bus_if.aluout    = 16'h8000;
    bus_if.dr        = 3'd6;
    bus_if.wb_valid  = 1'b1;
    tick();
    reset = 1'b0;
    bus_if.wb_valid = 1'b0;
    check_eq("rst2_psr", {29'd0, bus_if.psr}, 32'd0);
    check_eq("rst2_ready", {31'd0, bus_if.wb_ready}, 32'd0);
    check_eq("rst2_busy1", {31'd0, bus_if.sr2_busy}, 32'd0);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("clr2_ready%0d", i), {31'd0, bus_if.wb_ready}, 32'd0);
      tick();
    end
    check_eq("clr2_done_ready", {31'd0, bus_if.wb_ready}, 32'd1);
    check_eq("clr2_done_init", {31'd0, bus_if.init_done}, 32'd1);
    check_eq("clr2_r6", {16'd0, bus_if.VSR1}, 32'h0);
    check_eq("clr2_psr", {29'd0, bus_if.psr}, 32'd0);
    check_eq("clr2_busy1", {31'd0, bus_if.sr2_busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/writeback_rf_sb.md
Name: writeback_rf_sb

Overview:
- Parametrised writeback stage and register file for the LC-3-class pipeline controller.
- Selects the writeback source and writes the register file under a valid/ready handshake.
- Updates NZP condition codes and keeps a per-register pending-write scoreboard used by decode for hazard detection.
- After reset, a hardware clear sequence zeroes every register before writebacks are accepted.

Parameters:
- DATA_W, 16, datapath and register width in bits (>=2).
- ADDR_W, 3, register index width; the register count is NREGS = 2**ADDR_W.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- wb_valid  in  1  writeback request valid.
- wb_ready  out  1  stage can accept a writeback.
- W_Control  in  2  source select: 0 aluout, 1 memout, 2 pcout, 3 npc.
- aluout  in  DATA_W  ALU result.
- memout  in  DATA_W  memory load data.
- pcout  in  DATA_W  computed PC or address value.
- npc  in  DATA_W  next-PC value.
- dr  in  ADDR_W  writeback destination register.
- iss_valid  in  1  an instruction with a destination is issuing.
- iss_dr  in  ADDR_W  destination of the issuing instruction.
- sr1, sr2  in  ADDR_W  read addresses.
- VSR1, VSR2  out  DATA_W  read data.
- sr1_busy, sr2_busy  out  1  a write to sr1 or sr2 is pending.
- psr  out  3  condition codes {N,Z,P}.
- init_done  out  1  clear sequence is complete.

Behaviour:
- reset: reset, synchronous, active-high; clock: clock.
- Reset values: psr=3'b000, wb_ready=0, init_done=0, all busy bits 0, clear counter 0, FSM=CLEAR.
- Reset has priority over every other event, in any state, including mid-CLEAR or alongside an accepted writeback. The clear sequence restarts from register 0.
- FSM state CLEAR:
  - Writes 0 to register[cnt] each cycle and increments cnt.
  - When cnt == NREGS-1 is written, the FSM moves to RUN on that edge.
  - The clear takes exactly NREGS cycles; cnt never wraps back to 0.
  - wb_ready=0 and init_done=0 throughout.
  - iss_valid and wb_valid are ignored; no state changes from them.
- FSM state RUN: wb_ready=1 and init_done=1 as registered outputs, both first high the cycle after the last clear write. RUN exits only through reset.
- Source mux: din is a combinational select on W_Control (0 aluout, 1 memout, 2 pcout, 3 npc).
- Accept: wb_valid && wb_ready. On the accepting edge:
  - register[dr] <= din.
  - psr <= 3'b100 if din[DATA_W-1]; else 3'b001 if din != 0; else 3'b010.
  - busy[dr] <= 0.
  - Latency from accept to both the register update and psr is 1 edge.
  - psr holds its value when no writeback is accepted.
- Scoreboard:
  - iss_valid in RUN sets busy[iss_dr] on the edge.
  - If iss_dr == dr on an accepting edge, set wins and busy stays 1 (a newer producer is outstanding).
  - Different indices are set and cleared independently on the same edge.
- Reads:
  - VSR1 = register[sr1] and VSR2 = register[sr2], combinational.
  - sr1_busy = busy[sr1] and sr2_busy = busy[sr2], combinational.
  - sr1 == sr2 is legal and returns identical data.
- Unknown or undriven W_Control is not allowed; din must never latch.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: when a writeback is being accepted in the current cycle and sr1 == dr (or sr2 == dr), VSR1 (or VSR2) returns din combinationally. The matching sr*_busy reads 0 unless an iss_valid to the same index occurs in that cycle.
- Undefined: reads return the stored value until the write edge; no bypass path.

Test Plan:
- Clear sequence: pulse reset, DATA_W=16, ADDR_W=3 -> wb_ready=0 for 8 cycles, then 1. Reading all 8 registers returns 0x0000, init_done=1, psr=000.
- Writeback sources: accept W_Control=1, memout=0x8001, dr=3 -> next cycle VSR1(sr1=3)=0x8001, psr=100. Then aluout=0, dr=4 -> psr=010. Then npc=0x3001, dr=5 -> psr=001.
- Scoreboard: iss_valid iss_dr=2 -> sr1_busy(sr1=2)=1 next cycle. Accept writeback dr=2 -> busy cleared. Simultaneous iss_dr=2 and accept dr=2 -> busy stays 1 and register[2] is updated.
- Handshake gating: wb_valid held high during CLEAR with aluout=0x1234, dr=1 -> no write and psr unchanged until RUN. The first RUN edge writes 0x1234.
- Reset mid-operation: write 0x00FF to R6, set busy[1], assert reset at cycle 4 of a second clear -> all busy bits 0, psr=000, full 8-cycle clear repeated, R6 reads 0.
- Bypass (WB_BYPASS_EN defined): accept pcout=0x4000, dr=7 with sr2=7 -> VSR2=0x4000 in the same cycle. Without the macro, VSR2 shows the old value until the edge.
